riscv_fetch_queue: RTL and testbench

Parametrised instruction-fetch stage that decouples I-cache accesses from decode with a parcel queue. It fetches 32-bit words from the I-cache, stores them as 16-bit parcels in a circular queue of depth `QDEPTH`, and realigns mixed 16/32-bit (RVC) instructions from the queue head. Each instruction is delivered to ID through a registered valid/ready pipeline register. It sits between the I-cache and the ID stage and takes PC corrections from EX.

---
 rtl/riscv_fetch_queue.sv | 151 +++++++++++++++
 tb/tb_riscv_fetch_queue.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_queue.sv
// Instruction fetch stage: fetches 32-bit words from the I-cache into a 16-bit
// parcel queue, realigns mixed RVC/32-bit instructions and registers them for ID.
module riscv_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect,
    input  logic [31:0]             redirect_pc,
    output logic                    ICACHE_ren,
    output logic                    ICACHE_wen,
    output logic [29:0]             ICACHE_addr,
    output logic [31:0]             ICACHE_wdata,
    input  logic [31:0]             ICACHE_rdata,
    input  logic                    ICACHE_stall,
    input  logic                    id_ready,
    output logic                    inst_valid,
    output logic [31:0]             inst_ppl,
    output logic [31:0]             pc_ppl,
    output logic                    compressed_ppl,
    output logic [31:0]             PC,
    output logic [$clog2(QDEPTH):0] queue_count
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = PW + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic        valid;
        logic [31:0] inst;
        logic [31:0] pc;
        logic        c;
    } fq_out_t;

    logic [QDEPTH-1:0][15:0] mem;
    logic [PW-1:0]           head, tail;
    logic [CW-1:0]           count;
    logic [31:0]             fpc, hpc;
    logic                    pend, drop;
    logic [29:0]             req_addr;
    fq_out_t                 out_q;

    logic                    can_issue, done, push_en, push_two;
    logic [PW-1:0]           head_p1, tail_p1;
    logic [15:0]             p0, p1;
    logic                    need_two, avail, load;
    logic [1:0]              n_push, n_pop;
    logic                    unused_pc0;

    assign unused_pc0 = redirect_pc[0];

    // Free space is judged on the registered count so the request never depends on this cycle's pops.
    assign can_issue    = (count <= CW'(QDEPTH - 2));
    assign ICACHE_ren   = rst_n & (pend | can_issue);
    assign ICACHE_addr  = pend ? req_addr : fpc[31:2];
    assign ICACHE_wen   = 1'b0;
    assign ICACHE_wdata = 32'h0;

    assign done     = ICACHE_ren & ~ICACHE_stall;
    assign push_en  = done & ~drop & ~redirect;
    assign push_two = ~fpc[1];
    assign n_push   = push_en ? (push_two ? 2'd2 : 2'd1) : 2'd0;

    assign head_p1  = head + PW'(1);
    assign tail_p1  = tail + PW'(1);
    assign p0       = mem[head];
    assign p1       = mem[head_p1];
    assign need_two = (p0[1:0] == 2'b11);
    assign avail    = need_two ? (count >= CW'(2)) : (count >= CW'(1));
    assign load     = avail & (~out_q.valid | id_ready) & ~redirect;
    assign n_pop    = load ? (need_two ? 2'd2 : 2'd1) : 2'd0;

    always_ff @(posedge clk) begin
        if (push_en) begin
            if (push_two) begin
                mem[tail]    <= ICACHE_rdata[15:0];
                mem[tail_p1] <= ICACHE_rdata[31:16];
            end else begin
                mem[tail]    <= ICACHE_rdata[31:16];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fpc      <= {RESET_PC[31:1], 1'b0};
            hpc      <= {RESET_PC[31:1], 1'b0};
            pend     <= 1'b0;
            drop     <= 1'b0;
            req_addr <= '0;
        end else begin
            pend     <= ICACHE_ren & ICACHE_stall;
            req_addr <= ICACHE_addr;
            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
                fpc   <= {redirect_pc[31:1], 1'b0};
                hpc   <= {redirect_pc[31:1], 1'b0};
                // A request still stalled keeps its old address; its data must be thrown away.
                drop  <= ICACHE_ren & ICACHE_stall;
            end else begin
                if (done && drop)
                    drop <= 1'b0;
                if (done && !drop)
                    fpc <= {fpc[31:2] + 30'd1, 2'b00};
                tail  <= tail + PW'(n_push);
                head  <= head + PW'(n_pop);
                count <= count + CW'(n_push) - CW'(n_pop);
                if (load)
                    hpc <= hpc + (need_two ? 32'd4 : 32'd2);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '{valid: 1'b0, inst: NOP, pc: 32'h0, c: 1'b0};
        end else if (redirect) begin
            out_q.valid <= 1'b0;
            out_q.inst  <= NOP;
            out_q.c     <= 1'b0;
        end else if (load) begin
            out_q.valid <= 1'b1;
            out_q.inst  <= need_two ? {p1, p0} : {16'h0, p0};
            out_q.pc    <= hpc;
            out_q.c     <= ~need_two;
        end else if (id_ready) begin
            out_q.valid <= 1'b0;
            out_q.inst  <= NOP;
        end
    end

    assign inst_valid     = out_q.valid;
    assign inst_ppl       = out_q.inst;
    assign pc_ppl         = out_q.pc;
    assign compressed_ppl = out_q.c;
    assign PC             = fpc;
    assign queue_count    = count;

    a_no_underflow: assert property (@(posedge clk) disable iff (!rst_n)
        CW'(n_pop) <= count);
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        ((CW+1)'(count) + (CW+1)'(n_push) - (CW+1)'(n_pop)) <= (CW+1)'(QDEPTH));

endmodule

// File: tb/tb_riscv_fetch_queue.sv
// Directed bench for riscv_fetch_queue: reset, RVC realignment, backpressure,
// redirects during stalls, odd redirect targets and redirect collisions.
module tb_riscv_fetch_queue;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        icache_ren, icache_wen;
    logic [29:0] icache_addr;
    logic [31:0] icache_wdata, icache_rdata;
    logic        icache_stall = 1'b0;
    logic        id_ready = 1'b1;
    logic        inst_valid, compressed_ppl;
    logic [31:0] inst_ppl, pc_ppl, fpc;
    logic [3:0]  queue_count;

    logic [31:0] tbmem [256];
    logic [31:0] cap_inst [$];
    logic [31:0] cap_pc [$];
    logic        cap_c [$];
    int n_chk = 0;
    int n_err = 0;

    riscv_fetch_queue #(.RESET_PC(32'h0), .QDEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .redirect(redirect), .redirect_pc(redirect_pc),
        .ICACHE_ren(icache_ren), .ICACHE_wen(icache_wen), .ICACHE_addr(icache_addr),
        .ICACHE_wdata(icache_wdata), .ICACHE_rdata(icache_rdata), .ICACHE_stall(icache_stall),
        .id_ready(id_ready), .inst_valid(inst_valid), .inst_ppl(inst_ppl), .pc_ppl(pc_ppl),
        .compressed_ppl(compressed_ppl), .PC(fpc), .queue_count(queue_count)
    );

    always #5 clk = ~clk;
    assign icache_rdata = tbmem[icache_addr[7:0]];

    // Record every instruction ID takes, mid-cycle when inputs and outputs are settled.
    always @(negedge clk) begin
        if (rst_n && inst_valid && id_ready && !redirect) begin
            cap_inst.push_back(inst_ppl);
            cap_pc.push_back(pc_ppl);
            cap_c.push_back(compressed_ppl);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic flush_cap;
        cap_inst.delete();
        cap_pc.delete();
        cap_c.delete();
    endtask

    task automatic chk_cap(input string tag, input int idx, input logic [31:0] inst,
                           input logic [31:0] pc, input logic c);
        chk({tag, "_inst"}, (idx < cap_inst.size()) ? cap_inst[idx] : 32'hDEAD_BEEF, inst);
        chk({tag, "_pc"},   (idx < cap_pc.size())   ? cap_pc[idx]   : 32'hDEAD_BEEF, pc);
        chk({tag, "_c"},    (idx < cap_c.size())    ? 32'(cap_c[idx]) : 32'hDEAD_BEEF, 32'(c));
    endtask

    initial begin
        int viol;
        for (int i = 0; i < 256; i++) tbmem[i] = (32'(i) << 7) | 32'h13;
        tbmem[8'h00] = 32'h0050_0093;
        tbmem[8'h10] = 32'h0093_4505;
        tbmem[8'h11] = 32'h4585_0050;
        tbmem[8'h40] = 32'h4585_2013;

        // reset state
        #1 rst_n = 1'b0;
        tick(2);
        chk("rst_ren", 32'(icache_ren), 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_inst", inst_ppl, 32'h13);
        chk("rst_pc", pc_ppl, 32'h0);
        chk("rst_c", 32'(compressed_ppl), 32'd0);
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_fpc", fpc, 32'h0);
        chk("wen", 32'(icache_wen), 32'd0);
        chk("wdata", icache_wdata, 32'h0);

        // reset fetch: first completion now, valid two edges later
        rst_n = 1'b1;
        #1;
        chk("first_ren", 32'(icache_ren), 32'd1);
        chk("first_addr", {2'b00, icache_addr}, 32'h0);
        tick;
        chk("first_count", 32'(queue_count), 32'd2);
        chk("first_valid_n1", 32'(inst_valid), 32'd0);
        chk("first_fpc", fpc, 32'h4);
        tick;
        chk("first_valid", 32'(inst_valid), 32'd1);
        chk("first_inst", inst_ppl, 32'h0050_0093);
        chk("first_pc", pc_ppl, 32'h0);
        chk("first_c", 32'(compressed_ppl), 32'd0);

        // mixed RVC with a split 32-bit instruction
        redirect = 1'b1; redirect_pc = 32'h40; flush_cap();
        tick;
        redirect = 1'b0;
        tick(8);
        chk_cap("rvc0", 0, 32'h0000_4505, 32'h40, 1'b1);
        chk_cap("rvc1", 1, 32'h0050_0093, 32'h42, 1'b0);
        chk_cap("rvc2", 2, 32'h0000_4585, 32'h46, 1'b1);
        chk_cap("rvc3", 3, 32'h0000_0913, 32'h48, 1'b0);

        // backpressure: queue fills, fetch stops, nothing lost after release
        redirect = 1'b1; redirect_pc = 32'h80; id_ready = 1'b0; flush_cap();
        tick;
        redirect = 1'b0;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
            if (icache_ren && queue_count > 4'd6) viol++;
            if (queue_count > 4'd8) viol++;
            tick;
        end
        chk("bp_viol", 32'(viol), 32'd0);
        chk("bp_count", 32'(queue_count), 32'd8);
        chk("bp_ren", 32'(icache_ren), 32'd0);
        chk("bp_valid", 32'(inst_valid), 32'd1);
        chk("bp_inst", inst_ppl, 32'h1013);
        chk("bp_pc", pc_ppl, 32'h80);
        chk("bp_none", 32'(cap_inst.size()), 32'd0);
        id_ready = 1'b1;
        tick(10);
        chk("bp_rate", 32'(cap_inst.size()), 32'd10);
        for (int k = 0; k < 10; k++)
            chk_cap("bp_seq", k, ((32'h20 + 32'(k)) << 7) | 32'h13, 32'h80 + 32'(4 * k), 1'b0);

        // redirect in the first of three stalled cycles
        redirect = 1'b1; redirect_pc = 32'hC0; flush_cap();
        tick;
        redirect_pc = 32'h100; icache_stall = 1'b1; flush_cap();
        #1;
        chk("rs_ren", 32'(icache_ren), 32'd1);
        chk("rs_addr0", {2'b00, icache_addr}, 32'h30);
        tick;
        redirect = 1'b0;
        chk("rs_addr1", {2'b00, icache_addr}, 32'h30);
        chk("rs_ren1", 32'(icache_ren), 32'd1);
        chk("rs_fpc", fpc, 32'h100);
        chk("rs_count1", 32'(queue_count), 32'd0);
        chk("rs_valid1", 32'(inst_valid), 32'd0);
        tick;
        chk("rs_addr2", {2'b00, icache_addr}, 32'h30);
        tick;
        icache_stall = 1'b0;
        chk("rs_addr3", {2'b00, icache_addr}, 32'h30);
        tick;
        chk("rs_addr_new", {2'b00, icache_addr}, 32'h40);
        chk("rs_dropped", 32'(queue_count), 32'd0);
        tick(6);
        chk_cap("rs0", 0, 32'h4585_2013, 32'h100, 1'b0);
        chk_cap("rs1", 1, 32'h0000_2093, 32'h104, 1'b0);

        // odd redirect target: only the upper parcel of the word is pushed
        redirect = 1'b1; redirect_pc = 32'h102; flush_cap();
        tick;
        redirect = 1'b0;
        chk("odd_addr", {2'b00, icache_addr}, 32'h40);
        chk("odd_fpc", fpc, 32'h102);
        tick;
        chk("odd_count", 32'(queue_count), 32'd1);
        chk("odd_fpc2", fpc, 32'h104);
        tick(5);
        chk_cap("odd0", 0, 32'h0000_4585, 32'h102, 1'b1);
        chk_cap("odd1", 1, 32'h0000_2093, 32'h104, 1'b0);

        // redirect colliding with a completion and an ID acceptance
        chk("sim_ren", 32'(icache_ren), 32'd1);
        chk("sim_valid", 32'(inst_valid), 32'd1);
        redirect = 1'b1; redirect_pc = 32'h180; flush_cap();
        tick;
        redirect = 1'b0;
        chk("sim_count", 32'(queue_count), 32'd0);
        chk("sim_valid0", 32'(inst_valid), 32'd0);
        chk("sim_inst", inst_ppl, 32'h13);
        chk("sim_c", 32'(compressed_ppl), 32'd0);
        chk("sim_fpc", fpc, 32'h180);
        tick(6);
        chk_cap("sim0", 0, 32'h0000_3013, 32'h180, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
